imm_instr_encoder: RTL and testbench
====================================

# imm_instr_encoder

Instruction encoder and program loader for the RISC-V datapath. It accepts decoded instruction fields (opcode, registers, funct3, and an immediate as a 32-bit value), checks that the immediate fits the instruction's format, and packs them into a 32-bit instruction word. It then writes the word sequentially into instruction memory. The packing is the exact inverse of the datapath's immediate extraction, so a written word decodes back to the same immediate value.

## Interface
Parameters:
- ADDR_WIDTH, 6, width of the instruction-memory word address
- DEPTH, 64, maximum number of words written per load session (≤ 2^ADDR_WIDTH)
- BASE_ADDR, 0, word address of the first write

Ports:
- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start_i  in  1  begin a load session (honoured only in IDLE)
- valid_i  in  1  instruction fields valid this cycle
- last_i  in  1  this beat is the final instruction of the session
- ready_o  out  1  encoder accepts a beat this cycle
- op_i  in  7  opcode
- rd_i, rs1_i, rs2_i  in  5 each  register fields
- funct3_i  in  3  funct3 field
- imm_i  in  32  immediate as a signed or unsigned value
- we_o  out  1  instruction-memory write strobe
- waddr_o  out  ADDR_WIDTH  write word address
- wdata_o  out  32  encoded instruction
- err_o  out  1  one-cycle pulse: the immediate was out of range and the beat was dropped
- err_cnt_o  out  8  dropped beats this session (saturates at 255)
- count_o  out  ADDR_WIDTH+1  words written this session
- done_o  out  1  one-cycle pulse: session complete
- full_o  out  1  session ended because DEPTH was reached (held until next start)

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE: ready_o=0. On start_i: go to LOAD; clear count_o, err_cnt_o and full_o; set the address pointer to BASE_ADDR.
  - LOAD: ready_o=1. A beat is accepted when valid_i && ready_o. Go to DONE when an accepted beat has last_i=1, or when an accepted write makes count reach DEPTH. In the DEPTH case, set full_o.
  - DONE: done_o=1 for one cycle, then go to IDLE. ready_o=0.
- start_i in LOAD or DONE is ignored.
- Encoding and range rules, selected by op_i (same selection order as the datapath decoder):
  - op 0x13 or 0x03 (I format):
    - Legal imm: -2048..2047 (two's complement).
    - Word = {imm[11:0], rs1, funct3, rd, op}.
  - op 0x23 (S format; the decoder zero-extends):
    - Legal imm: 0..4095.
    - Word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - Any other op (U format; the decoder sign-extends 20 bits, unshifted):
    - Legal imm: -524288..524287.
    - Word = {imm[19:0], rd, op}.
- Illegal immediate: no write; err_o pulses; err_cnt_o increments; pointer and count_o unchanged. Dropped beats do not consume DEPTH. A dropped beat with last_i=1 still ends the session.
- Legal beat: write at the pointer, then pointer+1 and count_o+1.

## Timing
- Latency is 1 cycle. For a beat accepted at edge N, we_o, waddr_o, wdata_o (or err_o) are registered and valid for the cycle after edge N.
- Back-to-back beats sustain one write per cycle.
- The final beat's write and done_o are asserted in the same cycle.
- Reset values:
  - state IDLE.
  - ready_o, we_o, err_o, done_o, full_o = 0.
  - waddr_o = BASE_ADDR; wdata_o, count_o, err_cnt_o = 0.
- Reset mid-LOAD aborts the session immediately. A pending write is not issued.
- The pointer never wraps, because DEPTH bounds it.

## Test plan
- I format: start, then beat op=0x13, rd=5, rs1=6, f3=0, imm=0xFFFFFFFF (-1), last=1.
  - Expect next cycle: we_o=1, waddr_o=0, wdata_o=0xFFF30293, done_o=1.
  - Then IDLE, count_o=1.
- S format: beat op=0x23, rs1=2, rs2=7, f3=2, imm=20 → wdata_o=0x00712A23.
- U format: beat op=0x37, rd=10, imm=0x12345 → wdata_o=0x12345537.
- Range errors and streaming:
  - Stream I imm=2048, then S imm=-1, then I imm=-2048, each back-to-back.
  - Expect err_o on cycles 1 and 2 with no we_o; cycle 3 writes 0x80000013|fields at address 0.
  - err_cnt_o=2, count_o=1.
- Full (DEPTH=4): hold valid_i with last_i=0 for 4 legal beats.
  - Expect writes at addresses 0..3.
  - done_o and full_o=1 with the 4th write; ready_o=0 afterwards.
- Reset: assert reset in LOAD after 2 writes.
  - Expect ready_o, we_o = 0 next cycle.
  - A new start writes from BASE_ADDR with count_o=0.

Source files
------------

// File: rtl/imm_instr_encoder_if.sv
// Field/handshake bundle between an instruction source and the encoder,
// plus the encoder's instruction-memory write port.
interface imm_instr_encoder_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  start_i;
  logic                  valid_i;
  logic                  last_i;
  logic                  ready_o;
  logic [6:0]            op_i;
  logic [4:0]            rd_i;
  logic [4:0]            rs1_i;
  logic [4:0]            rs2_i;
  logic [2:0]            funct3_i;
  logic [31:0]           imm_i;
  logic                  we_o;
  logic [ADDR_WIDTH-1:0] waddr_o;
  logic [31:0]           wdata_o;
  logic                  err_o;
  logic [7:0]            err_cnt_o;
  logic [ADDR_WIDTH:0]   count_o;
  logic                  done_o;
  logic                  full_o;

  modport master (
    output start_i, valid_i, last_i, op_i, rd_i, rs1_i, rs2_i, funct3_i, imm_i,
    input  ready_o, we_o, waddr_o, wdata_o, err_o, err_cnt_o, count_o, done_o, full_o
  );

  modport slave (
    input  start_i, valid_i, last_i, op_i, rd_i, rs1_i, rs2_i, funct3_i, imm_i,
    output ready_o, we_o, waddr_o, wdata_o, err_o, err_cnt_o, count_o, done_o, full_o
  );
endinterface

// File: rtl/imm_instr_encoder.sv
// Packs decoded fields into RISC-V words (inverse of the datapath immediate
// extraction), range-checks the immediate and streams words into imem.
module imm_instr_encoder #(
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64,
  parameter int BASE_ADDR  = 0
) (
  input  logic clk,
  input  logic reset,
  imm_instr_encoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
  } req_t;

  state_t                state;
  req_t                  req;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  at_depth;
  logic                  imm_ok;
  logic [31:0]           word;

  assign req = '{op: bus.op_i, rd: bus.rd_i, rs1: bus.rs1_i, rs2: bus.rs2_i,
                 f3: bus.funct3_i, imm: bus.imm_i};

  assign count_nxt = bus.count_o + 1'b1;
  assign at_depth  = (count_nxt == (ADDR_WIDTH+1)'(DEPTH));

  // Format selection mirrors the decoder: I, then S, everything else is U.
  // S is zero-extended by the decoder, so negative S immediates are illegal.
  always_comb begin
    imm_ok = 1'b0;
    word   = '0;
    if (req.op == 7'h13 || req.op == 7'h03) begin
      imm_ok = (&req.imm[31:11]) | ~(|req.imm[31:11]);
      word   = {req.imm[11:0], req.rs1, req.f3, req.rd, req.op};
    end else if (req.op == 7'h23) begin
      imm_ok = ~(|req.imm[31:12]);
      word   = {req.imm[11:5], req.rs2, req.rs1, req.f3, req.imm[4:0], req.op};
    end else begin
      imm_ok = (&req.imm[31:19]) | ~(|req.imm[31:19]);
      word   = {req.imm[19:0], req.rd, req.op};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= ADDR_WIDTH'(BASE_ADDR);
      bus.ready_o   <= 1'b0;
      bus.we_o      <= 1'b0;
      bus.err_o     <= 1'b0;
      bus.done_o    <= 1'b0;
      bus.full_o    <= 1'b0;
      bus.waddr_o   <= ADDR_WIDTH'(BASE_ADDR);
      bus.wdata_o   <= '0;
      bus.count_o   <= '0;
      bus.err_cnt_o <= '0;
    end else begin
      bus.we_o   <= 1'b0;
      bus.err_o  <= 1'b0;
      bus.done_o <= 1'b0;
      case (state)
        IDLE: if (bus.start_i) begin
          state         <= LOAD;
          bus.ready_o   <= 1'b1;
          bus.count_o   <= '0;
          bus.err_cnt_o <= '0;
          bus.full_o    <= 1'b0;
          ptr           <= ADDR_WIDTH'(BASE_ADDR);
        end
        LOAD: if (bus.valid_i && bus.ready_o) begin
          if (imm_ok) begin
            bus.we_o    <= 1'b1;
            bus.waddr_o <= ptr;
            bus.wdata_o <= word;
            ptr         <= ptr + 1'b1;
            bus.count_o <= count_nxt;
            if (at_depth) bus.full_o <= 1'b1;
          end else begin
            bus.err_o <= 1'b1;
            if (bus.err_cnt_o != 8'hFF) bus.err_cnt_o <= bus.err_cnt_o + 1'b1;
          end
          // Final write and done_o land in the same output cycle.
          if (bus.last_i || (imm_ok && at_depth)) begin
            state       <= DONE;
            bus.ready_o <= 1'b0;
            bus.done_o  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imm_instr_encoder.sv
// Directed bench for imm_instr_encoder: a per-cycle behavioural model checks
// every output, and hand-computed literals pin the model.
module tb_imm_instr_encoder;
  localparam int AW    = 6;
  localparam int DEPTH = 4;
  localparam int BASE  = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  imm_instr_encoder_if #(.ADDR_WIDTH(AW)) bus();
  imm_instr_encoder #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int ph, ptr, cnt, ec, m_waddr;
  bit m_ready, m_we, m_err, m_done, m_full, armed;
  bit [31:0] m_wdata;

  function automatic void model_enc(input bit [6:0] op, input bit [4:0] rd, rs1, rs2,
                                    input bit [2:0] f3, input logic [31:0] imm,
                                    output bit ok, output bit [31:0] w);
    int s;
    bit [31:0] u, o, d, r1, r2, f;
    s = imm; u = imm; o = 32'(op); d = 32'(rd); r1 = 32'(rs1); r2 = 32'(rs2); f = 32'(f3);
    if (op == 7'h13 || op == 7'h03) begin
      ok = (s >= -2048) && (s <= 2047);
      w  = ((u & 32'hFFF) << 20) | (r1 << 15) | (f << 12) | (d << 7) | o;
    end else if (op == 7'h23) begin
      ok = (s >= 0) && (s <= 4095);
      w  = (((u >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f << 12) | ((u & 32'h1F) << 7) | o;
    end else begin
      ok = (s >= -524288) && (s <= 524287);
      w  = ((u & 32'hFFFFF) << 12) | (d << 7) | o;
    end
  endfunction

  always @(posedge clk) begin
    bit ok;
    bit [31:0] w;
    m_we = 0; m_err = 0; m_done = 0;
    if (reset) begin
      ph = 0; m_ready = 0; m_full = 0; m_waddr = BASE; m_wdata = 0;
      cnt = 0; ec = 0; ptr = BASE; armed = 1;
    end else if (ph == 0) begin
      if (bus.start_i) begin
        ph = 1; m_ready = 1; cnt = 0; ec = 0; m_full = 0; ptr = BASE;
      end
    end else if (ph == 2) begin
      ph = 0;
    end else if (bus.valid_i) begin
      model_enc(bus.op_i, bus.rd_i, bus.rs1_i, bus.rs2_i, bus.funct3_i, bus.imm_i, ok, w);
      if (ok) begin
        m_we = 1; m_waddr = ptr; m_wdata = w; ptr++; cnt++;
        if (cnt == DEPTH) m_full = 1;
      end else begin
        m_err = 1;
        if (ec < 255) ec++;
      end
      if (bus.last_i || m_full) begin
        ph = 2; m_ready = 0; m_done = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if (bus.ready_o !== m_ready || bus.we_o !== m_we || bus.err_o !== m_err ||
          bus.done_o !== m_done || bus.full_o !== m_full ||
          bus.waddr_o !== AW'(m_waddr) || bus.wdata_o !== m_wdata ||
          bus.count_o !== (AW+1)'(cnt) || bus.err_cnt_o !== 8'(ec)) begin
        failures++;
        $display("FAIL model t=%0t got rdy=%b we=%b err=%b done=%b full=%b wa=%0d wd=%h cnt=%0d ec=%0d exp rdy=%b we=%b err=%b done=%b full=%b wa=%0d wd=%h cnt=%0d ec=%0d",
                 $time, bus.ready_o, bus.we_o, bus.err_o, bus.done_o, bus.full_o, bus.waddr_o,
                 bus.wdata_o, bus.count_o, bus.err_cnt_o, m_ready, m_we, m_err, m_done, m_full,
                 m_waddr, m_wdata, cnt, ec);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
  endtask

  task automatic send(input bit [6:0] op, input bit [4:0] rd, rs1, rs2, input bit [2:0] f3,
                      input logic [31:0] imm, input bit last);
    bus.valid_i = 1'b1; bus.op_i = op; bus.rd_i = rd; bus.rs1_i = rs1; bus.rs2_i = rs2;
    bus.funct3_i = f3; bus.imm_i = imm; bus.last_i = last;
    tick();
  endtask

  task automatic idle();
    bus.valid_i = 1'b0; bus.last_i = 1'b0; tick();
  endtask

  initial begin
    bus.start_i = 0; bus.valid_i = 0; bus.last_i = 0; bus.op_i = 0; bus.rd_i = 0;
    bus.rs1_i = 0; bus.rs2_i = 0; bus.funct3_i = 0; bus.imm_i = 0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", 32'(bus.ready_o), 0);
    chk("rst_waddr", 32'(bus.waddr_o), BASE);
    chk("rst_count", 32'(bus.count_o), 0);
    tick();

    // I format
    do_start();
    chk("load_ready", 32'(bus.ready_o), 1);
    send(7'h13, 5, 6, 0, 0, 32'hFFFF_FFFF, 1);
    chk("i_we", 32'(bus.we_o), 1);
    chk("i_waddr", 32'(bus.waddr_o), 0);
    chk("i_wdata", bus.wdata_o, 32'hFFF3_0293);
    chk("i_done", 32'(bus.done_o), 1);
    idle();
    chk("i_count", 32'(bus.count_o), 1);
    chk("i_ready", 32'(bus.ready_o), 0);
    idle();

    // S format
    do_start();
    send(7'h23, 0, 2, 7, 2, 32'd20, 1);
    chk("s_wdata", bus.wdata_o, 32'h0071_2A23);
    idle(); idle();

    // U format
    do_start();
    send(7'h37, 10, 0, 0, 0, 32'h0001_2345, 1);
    chk("u_wdata", bus.wdata_o, 32'h1234_5537);
    idle(); idle();

    // Range errors, back-to-back
    do_start();
    send(7'h13, 1, 2, 0, 0, 32'd2048, 0);
    chk("e1_err", 32'(bus.err_o), 1);
    chk("e1_we", 32'(bus.we_o), 0);
    send(7'h23, 1, 2, 3, 0, 32'hFFFF_FFFF, 0);
    chk("e2_err", 32'(bus.err_o), 1);
    send(7'h13, 1, 2, 0, 0, 32'hFFFF_F800, 1);
    chk("e3_we", 32'(bus.we_o), 1);
    chk("e3_waddr", 32'(bus.waddr_o), 0);
    chk("e3_wdata", bus.wdata_o, 32'h8001_0093);
    chk("e3_done", 32'(bus.done_o), 1);
    idle();
    chk("e_errcnt", 32'(bus.err_cnt_o), 2);
    chk("e_count", 32'(bus.count_o), 1);
    idle();

    // Full: a dropped beat mid-stream does not consume DEPTH; start ignored in LOAD
    do_start();
    send(7'h37, 1, 0, 0, 0, 32'd1, 0);
    bus.start_i = 1'b1;
    send(7'h37, 2, 0, 0, 0, 32'd2, 0);
    bus.start_i = 1'b0;
    send(7'h37, 3, 0, 0, 0, 32'h0008_0000, 0);
    send(7'h37, 4, 0, 0, 0, 32'hFFF8_0000, 0);
    send(7'h6F, 5, 0, 0, 0, 32'd5, 0);
    chk("f_waddr", 32'(bus.waddr_o), 3);
    chk("f_done", 32'(bus.done_o), 1);
    chk("f_full", 32'(bus.full_o), 1);
    idle();
    chk("f_ready", 32'(bus.ready_o), 0);
    chk("f_hold", 32'(bus.full_o), 1);
    chk("f_count", 32'(bus.count_o), 4);
    idle();
    do_start();
    chk("f_clear", 32'(bus.full_o), 0);

    // err_cnt saturation
    for (int i = 0; i < 260; i++) send(7'h03, 1, 1, 0, 0, 32'd4096, 0);
    send(7'h03, 1, 1, 0, 0, 32'd7, 1);
    chk("sat_errcnt", 32'(bus.err_cnt_o), 255);
    idle(); idle();

    // Reset mid-LOAD with a pending beat
    do_start();
    send(7'h13, 1, 0, 0, 0, 32'd1, 0);
    send(7'h13, 2, 0, 0, 0, 32'd2, 0);
    bus.valid_i = 1'b1; reset = 1'b1; tick();
    chk("r_ready", 32'(bus.ready_o), 0);
    chk("r_we", 32'(bus.we_o), 0);
    bus.valid_i = 1'b0; reset = 1'b0; tick();
    do_start();
    chk("r_count", 32'(bus.count_o), 0);
    send(7'h13, 3, 0, 0, 0, 32'd3, 1);
    chk("r_waddr", 32'(bus.waddr_o), BASE);
    idle(); idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
